// File: rtl/atto_bus_arbiter_pkg.sv
// Shared definitions for the atto memory-bus arbiter.
//   - FSM state encoding
//   - requester port indices
//   - bus widths
//   - one-hot helper for the ack vector
package atto_bus_pkg;

  localparam int DATA_W    = 8;
  localparam int ADDR_W    = 16;
  localparam int PORT_CORE = 0;
  localparam int PORT_DMA  = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Map a granted port index to its ack bit.
  function automatic logic [1:0] port_onehot(input logic port);
    return (port == 1'(PORT_DMA)) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/atto_bus_arbiter_if.sv
// Bundles the two requester ports and the external memory pins.
//   - slave  : the arbiter side
//     - inputs  : requests, write enables, addresses, write data, pad data
//     - outputs : acks, read data, memory address/direction/data/enable
//   - master : the requesters plus the board memory (mirror image)
interface atto_bus_arbiter_if;
  import atto_bus_pkg::*;

  logic [1:0]        req;
  logic [1:0]        we;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic [1:0]        ack;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] address_bus;
  logic              data_dir;
  logic [DATA_W-1:0] data_out;
  logic              data_oe;
  logic [DATA_W-1:0] data_in;

  modport slave (
    input  req, we, addr0, addr1, wdata0, wdata1, data_in,
    output ack, rdata, address_bus, data_dir, data_out, data_oe
  );

  modport master (
    output req, we, addr0, addr1, wdata0, wdata1, data_in,
    input  ack, rdata, address_bus, data_dir, data_out, data_oe
  );

endinterface

// File: rtl/atto_bus_arbiter_rr.sv
// Combinational two-way grant selection.
//   i_req        : per-port request
//   i_last_grant : port served by the previous transaction
//   o_grant      : index of the winning port (only meaningful when i_req != 0)
// When both ports request:
//   - round-robin  : the port that was not served last wins
//   - fixed priority: port 0 always wins
module atto_rr_arbiter
  import atto_bus_pkg::*;
#(
  parameter int FIXED_PRIORITY = 0
) (
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  output logic       o_grant
);

  always_comb begin
    o_grant = 1'(PORT_CORE);
    case (i_req)
      2'b10:   o_grant = 1'(PORT_DMA);
      2'b11:   o_grant = (FIXED_PRIORITY != 0) ? 1'(PORT_CORE) : ~i_last_grant;
      default: o_grant = 1'(PORT_CORE);
    endcase
  end

endmodule

// File: rtl/atto_bus_arbiter.sv
// Shares the external 8-bit data / 16-bit address memory bus between
// the core port (0) and the DMA/loader port (1).
//   i_clock : system clock, rising edge
//   i_reset : asynchronous, active-high reset
//   io_bus  : requester handshakes plus memory pins (slave modport)
//
// Every access takes WAIT_STATES+1 ACCESS cycles and then one DONE cycle,
// in which the granted port's ack bit pulses.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | bus released; picks a grant as soon as any request is seen
// ACCESS | address (and write data) on the pins; counts wait states
// DONE   | one-cycle ack to the granted port; bus released
module atto_bus_arbiter
  import atto_bus_pkg::*;
#(
  parameter int WAIT_STATES    = 1,
  parameter int FIXED_PRIORITY = 0
) (
  input logic               i_clock,
  input logic               i_reset,
  atto_bus_arbiter_if.slave io_bus
);

  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait_states
    $error("atto_bus_arbiter: WAIT_STATES must be within 0..15");
  end

  state_t            r_state;
  state_t            w_state_next;
  logic              w_load;
  logic              w_grant;
  logic              r_grant;
  logic              r_last_grant;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [3:0]        r_cnt;
  logic [DATA_W-1:0] r_rdata;
  logic [1:0]        r_ack;
  logic              w_drive;

  atto_rr_arbiter #(
    .FIXED_PRIORITY (FIXED_PRIORITY)
  ) u_rr (
    .i_req        (io_bus.req),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant)
  );

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    case (r_state)
      IDLE: begin
        if (io_bus.req != 2'b00) begin
          w_state_next = ACCESS;
          w_load       = 1'b1;
        end
      end
      ACCESS: begin
        if (r_cnt == 4'd0) w_state_next = DONE;
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_cnt        <= 4'd0;
      r_rdata      <= '0;
      r_ack        <= 2'b00;
    end else begin
      r_state <= w_state_next;
      if (w_load) begin
        r_grant <= w_grant;
        r_we    <= io_bus.we[w_grant];
        r_addr  <= w_grant ? io_bus.addr1  : io_bus.addr0;
        r_wdata <= w_grant ? io_bus.wdata1 : io_bus.wdata0;
        r_cnt   <= 4'(WAIT_STATES);
      end else if (r_state == ACCESS && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (r_state == ACCESS && r_cnt == 4'd0 && !r_we) r_rdata <= io_bus.data_in;
      // ack is registered: it rises on the edge that enters DONE
      r_ack <= (r_state == ACCESS && r_cnt == 4'd0) ? port_onehot(r_grant) : 2'b00;
      if (r_state == DONE) r_last_grant <= r_grant;
    end
  end

  // Pad drive is decoded from the state register so an async reset
  // releases the data pins immediately.
  assign w_drive            = (r_state == ACCESS) && r_we;
  assign io_bus.data_oe     = w_drive;
  assign io_bus.data_dir    = ~w_drive;
  assign io_bus.data_out    = w_drive ? r_wdata : '0;
  assign io_bus.address_bus = r_addr;
  assign io_bus.ack         = r_ack;
  assign io_bus.rdata       = r_rdata;

endmodule

// File: tb/tb_atto_bus_arbiter.sv
module tb_atto_bus_arbiter;

  logic clk;
  logic rst;

  int checks = 0;
  int errors = 0;

  atto_bus_arbiter_if ifa ();
  atto_bus_arbiter_if ifb ();
  atto_bus_arbiter_if ifc ();

  atto_bus_arbiter #(.WAIT_STATES(1), .FIXED_PRIORITY(0)) u_a (
    .i_clock (clk), .i_reset (rst), .io_bus (ifa));
  atto_bus_arbiter #(.WAIT_STATES(1), .FIXED_PRIORITY(1)) u_b (
    .i_clock (clk), .i_reset (rst), .io_bus (ifb));
  atto_bus_arbiter #(.WAIT_STATES(0), .FIXED_PRIORITY(0)) u_c (
    .i_clock (clk), .i_reset (rst), .io_bus (ifc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Board memory: read data is the low address byte plus 0x71.
  always_comb ifa.data_in = ifa.address_bus[7:0] + 8'h71;
  always_comb ifb.data_in = ifb.address_bus[7:0] + 8'h71;
  always_comb ifc.data_in = ifc.address_bus[7:0] + 8'h71;

  // Expected responses: {ack[1:0], rdata[7:0]}
  logic [9:0] q_a[$];
  logic [9:0] q_b[$];
  logic [9:0] q_c[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon_a
    logic [9:0] e;
    if (ifa.ack !== 2'b00) begin
      if (q_a.size() == 0) chk("a_unexpected_ack", {30'd0, ifa.ack}, 32'd0);
      else begin
        e = q_a.pop_front();
        chk("a_ack", {30'd0, ifa.ack}, {30'd0, e[9:8]});
        chk("a_rdata", {24'd0, ifa.rdata}, {24'd0, e[7:0]});
      end
    end
  end

  always @(negedge clk) begin : mon_b
    logic [9:0] e;
    if (ifb.ack !== 2'b00) begin
      if (q_b.size() == 0) chk("b_unexpected_ack", {30'd0, ifb.ack}, 32'd0);
      else begin
        e = q_b.pop_front();
        chk("b_ack", {30'd0, ifb.ack}, {30'd0, e[9:8]});
        chk("b_rdata", {24'd0, ifb.rdata}, {24'd0, e[7:0]});
      end
    end
  end

  always @(negedge clk) begin : mon_c
    logic [9:0] e;
    if (ifc.ack !== 2'b00) begin
      if (q_c.size() == 0) chk("c_unexpected_ack", {30'd0, ifc.ack}, 32'd0);
      else begin
        e = q_c.pop_front();
        chk("c_ack", {30'd0, ifc.ack}, {30'd0, e[9:8]});
        chk("c_rdata", {24'd0, ifc.rdata}, {24'd0, e[7:0]});
      end
    end
  end

  // Single transaction on instance A (WAIT_STATES=1); called at a negedge with A idle.
  task automatic txn_a(input int port, input logic wr, input logic [15:0] a,
                       input logic [7:0] d, input logic [7:0] exp_rdata, input string tag);
    int n;
    int match;
    bit got;
    q_a.push_back({(port == 1) ? 2'b10 : 2'b01, exp_rdata});
    if (port == 0) begin ifa.addr0 = a; ifa.wdata0 = d; ifa.we[0] = wr; end
    else           begin ifa.addr1 = a; ifa.wdata1 = d; ifa.we[1] = wr; end
    ifa.req[port] = 1'b1;
    n = 0; match = 0; got = 0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (ifa.ack[port]) got = 1;
      else if (ifa.address_bus == a && ifa.data_dir == !wr && ifa.data_oe == wr &&
               (!wr || ifa.data_out == d)) match++;
    end
    chk({tag, "_latency"}, n, 32'd3);
    chk({tag, "_access_cycles"}, match, 32'd2);
    chk({tag, "_done_oe"}, {31'd0, ifa.data_oe}, 32'd0);
    chk({tag, "_done_dir"}, {31'd0, ifa.data_dir}, 32'd1);
    ifa.req[port] = 1'b0;
    @(negedge clk);
    chk({tag, "_ack_single"}, {30'd0, ifa.ack}, 32'd0);
  endtask

  int n, acks, prev;

  initial begin
    rst = 1'b1;
    ifa.req = 2'b00; ifa.we = 2'b00; ifa.addr0 = '0; ifa.addr1 = '0; ifa.wdata0 = '0; ifa.wdata1 = '0;
    ifb.req = 2'b00; ifb.we = 2'b00; ifb.addr0 = '0; ifb.addr1 = '0; ifb.wdata0 = '0; ifb.wdata1 = '0;
    ifc.req = 2'b00; ifc.we = 2'b00; ifc.addr0 = '0; ifc.addr1 = '0; ifc.wdata0 = '0; ifc.wdata1 = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ack", {30'd0, ifa.ack}, 32'd0);
    chk("rst_rdata", {24'd0, ifa.rdata}, 32'd0);
    chk("rst_addr", {16'd0, ifa.address_bus}, 32'd0);
    chk("rst_dir", {31'd0, ifa.data_dir}, 32'd1);
    chk("rst_dout", {24'd0, ifa.data_out}, 32'd0);
    chk("rst_oe", {31'd0, ifa.data_oe}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Port 0 read 0x1234 -> 0xA5; port 1 write 0x00FF/0x3C leaves rdata at 0xA5.
    txn_a(0, 1'b0, 16'h1234, 8'h00, 8'hA5, "a_rd");
    txn_a(1, 1'b1, 16'h00FF, 8'h3C, 8'hA5, "a_wr");

    // Round-robin with both requests held: grants 0,1,0,1.
    ifa.addr0 = 16'h0100; ifa.addr1 = 16'h0210; ifa.we = 2'b00;
    q_a.push_back({2'b01, 8'h71}); q_a.push_back({2'b10, 8'h81});
    q_a.push_back({2'b01, 8'h71}); q_a.push_back({2'b10, 8'h81});
    ifa.req = 2'b11;
    n = 0; acks = 0; prev = -1;
    while (acks < 4 && n < 100) begin
      @(negedge clk);
      n++;
      if (ifa.ack != 2'b00) begin
        acks++;
        if (prev >= 0) chk("a_rr_spacing", n - prev, 32'd4);
        prev = n;
      end
    end
    chk("a_rr_count", acks, 32'd4);
    ifa.req = 2'b00;
    @(negedge clk);
    chk("a_rr_ack_single", {30'd0, ifa.ack}, 32'd0);

    // Async reset in the middle of a port-1 write.
    ifa.addr1 = 16'h0F0F; ifa.wdata1 = 8'h5A; ifa.we = 2'b10; ifa.req = 2'b10;
    @(negedge clk);
    chk("a_rst_pre_oe", {31'd0, ifa.data_oe}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("a_rst_oe", {31'd0, ifa.data_oe}, 32'd0);
    chk("a_rst_dir", {31'd0, ifa.data_dir}, 32'd1);
    chk("a_rst_ack", {30'd0, ifa.ack}, 32'd0);
    chk("a_rst_dout", {24'd0, ifa.data_out}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ifa.we = 2'b00; ifa.addr0 = 16'h0100; ifa.addr1 = 16'h0210; ifa.req = 2'b11;
    q_a.push_back({2'b01, 8'h71});
    n = 0;
    while (ifa.ack == 2'b00 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("a_tie_latency", n, 32'd3);
    chk("a_tie_port", {30'd0, ifa.ack}, 32'd1);
    ifa.req = 2'b00;
    @(negedge clk);

    // Fixed priority: port 0 served three times, port 1 only after port 0 drops.
    ifb.addr0 = 16'h0100; ifb.addr1 = 16'h0210; ifb.we = 2'b00;
    q_b.push_back({2'b01, 8'h71}); q_b.push_back({2'b01, 8'h71});
    q_b.push_back({2'b01, 8'h71}); q_b.push_back({2'b10, 8'h81});
    ifb.req = 2'b11;
    n = 0; acks = 0;
    while (acks < 4 && n < 100) begin
      @(negedge clk);
      n++;
      if (ifb.ack != 2'b00) begin
        acks++;
        if (acks == 3) ifb.req[0] = 1'b0;
        if (acks == 4) ifb.req = 2'b00;
      end
    end
    chk("b_fp_count", acks, 32'd4);
    @(negedge clk);

    // WAIT_STATES=0: port 0 drops req during ACCESS, ack still arrives in cycle 2.
    ifc.addr0 = 16'h0042; ifc.we = 2'b00; ifc.req = 2'b01;
    q_c.push_back({2'b01, 8'hB3});
    @(negedge clk);
    chk("c_access_addr", {16'd0, ifc.address_bus}, 32'h42);
    chk("c_access_ack", {30'd0, ifc.ack}, 32'd0);
    ifc.req = 2'b00;
    @(negedge clk);
    chk("c_ack_cycle2", {30'd0, ifc.ack}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("c_idle_ack", {30'd0, ifc.ack}, 32'd0);
      chk("c_idle_dir", {31'd0, ifc.data_dir}, 32'd1);
    end
    chk("c_idle_addr_hold", {16'd0, ifc.address_bus}, 32'h42);

    @(negedge clk);
    chk("a_pending", q_a.size(), 32'd0);
    chk("b_pending", q_b.size(), 32'd0);
    chk("c_pending", q_c.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    checks++;
    $display("FAIL global_timeout: simulation did not complete");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/atto_bus_arbiter.md
Name: atto_bus_arbiter

Overview:
- Shares the single external 8-bit data / 16-bit address memory bus between two requesters: port 0 (attocore fetch/load/store path) and port 1 (DMA/program loader).
- Accepts one request per port over a req/ack handshake, arbitrates, and runs the memory cycle with a fixed number of wait states.
- Returns read data with a one-cycle ack pulse.
- Sits between the core and the board memory; it is the only block that drives the memory pins.

Parameters:
- WAIT_STATES, 1, extra ACCESS cycles before read data is sampled (0..15).
- FIXED_PRIORITY, 0: 0 = round-robin; 1 = port 0 always wins.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req  in  2  per-port request, bit i = port i
- we  in  2  per-port write enable (1 = write, 0 = read)
- addr0  in  16  port 0 address
- addr1  in  16  port 1 address
- wdata0  in  8  port 0 write data
- wdata1  in  8  port 1 write data
- ack  out  2  per-port completion pulse
- rdata  out  8  read data, valid while any ack bit is high
- address_bus  out  16  memory address
- data_dir  out  1  1 = read/bus released, 0 = write
- data_out  out  8  write data to pad
- data_oe  out  1  pad output enable (top-level tristate uses it)
- data_in  in  8  data from pad

Behaviour:
- Reset (async, active-high):
  - state=IDLE, ack=0, rdata=0, address_bus=0, data_dir=1, data_out=0, data_oe=0.
  - last_grant=1, so port 0 wins the first tie.
  - Wait counter = 0.
- Requester rule: hold req[i], we[i], addr i and wdata i stable from assertion until the cycle ack[i] is high.
  - Requester may keep req high after ack for back-to-back accesses.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - If req==0: stay; outputs at idle values (data_dir=1, data_oe=0; address_bus holds last value).
  - Else: pick grant.
    - Only one bit set -> that port.
    - Both set, FIXED_PRIORITY=0 -> port != last_grant.
    - Both set, FIXED_PRIORITY=1 -> port 0.
  - Latch addr, we and wdata of the granted port.
  - Load counter=WAIT_STATES; go ACCESS.
- ACCESS (every cycle):
  - address_bus = latched addr.
  - Write: data_dir=0, data_oe=1, data_out = latched wdata.
  - Read: data_dir=1, data_oe=0.
  - counter!=0 -> decrement, stay.
  - counter==0 -> for reads, rdata <= data_in at this edge; go DONE.
- DONE (exactly one cycle):
  - ack[grant]=1, other ack bit 0.
  - data_dir=1, data_oe=0; rdata holds captured value (write: rdata unchanged).
  - last_grant <= grant; go IDLE.
- Latency:
  - req seen high at edge N -> ACCESS cycles N+1 .. N+1+WAIT_STATES -> ack high in cycle N+2+WAIT_STATES.
  - Back-to-back: next grant evaluated in the IDLE cycle after DONE.
  - Minimum spacing per transaction = WAIT_STATES+3 cycles.
- ack is registered, one-hot or zero, never high two consecutive cycles on the same port.
- req deasserted mid-transaction: transaction completes and ack still pulses; requester ignores it.
- Request arriving during ACCESS/DONE: not considered until next IDLE.
- Reset mid-ACCESS with a write: data_oe and data_dir go to idle values immediately (async); no ack is issued.
- Widths: counter 4 bits; WAIT_STATES>15 is illegal (elaboration assertion).

Decomposition:
- Package atto_bus_pkg:
  - State encoding (IDLE=0, ACCESS=1, DONE=2, 2-bit).
  - Port index constants PORT_CORE=0, PORT_DMA=1.
  - Data width 8, address width 16.
- Sub-module atto_rr_arbiter: combinational 2-way grant from req, last_grant and FIXED_PRIORITY.
  - Keeps the policy separately testable; the FSM, latches and counter stay in atto_bus_arbiter.

Test Plan:
- WAIT_STATES=1, port 0 read addr 0x1234, memory returns 0xA5:
  - address_bus=0x1234 with data_dir=1 for 2 cycles.
  - ack=2'b01 with rdata=0xA5 in cycle 3 after req sampled.
- Port 1 write addr 0x00FF, data 0x3C:
  - data_dir=0, data_oe=1, data_out=0x3C for WAIT_STATES+1 cycles.
  - ack=2'b10 one cycle.
  - data_oe=0 in DONE.
- Both req held high, FIXED_PRIORITY=0, 4 transactions: grants 0,1,0,1; no ack on both bits at once.
- Same stimulus, FIXED_PRIORITY=1: port 0 acked every transaction; port 1 acked only after port 0 drops req.
- Async reset pulse mid-ACCESS of a write: data_oe=0, data_dir=1 and ack=0 the same cycle; next req starts a fresh IDLE->ACCESS with port 0 winning the tie.
- WAIT_STATES=0, port 0 drops req during ACCESS: ack[0] still pulses once in cycle 2; FSM returns to IDLE and stays with req=0.
